// File: rtl/prbs_pkg.sv
// prbs_pkg: shared definitions for the ETROC PRBS test-pattern generator.
//   - mode encodings for the data_out selector
//   - default LFSR seed and frame period (one LHC orbit = 3564 bunch clocks)
//   - clog2 helper used to size the in-frame phase counter
package prbs_pkg;

  // Output mode encodings
  localparam logic [1:0] MODE_PRBS     = 2'd0;
  localparam logic [1:0] MODE_PHASE    = 2'd1;
  localparam logic [1:0] MODE_FIXED    = 2'd2;
  localparam logic [1:0] MODE_PRBS_INV = 2'd3;

  // Defaults for the generator
  localparam logic [16:0] DEFAULT_SEED   = 17'h0AAAA;
  localparam int          DEFAULT_PERIOD = 3564;

  // Number of bits needed to count 0..value-1, never less than 1
  function automatic int clog2(input int value);
    int width;
    int v;
    width = 0;
    v = value - 1;
    while (v > 0) begin
      width = width + 1;
      v = v >> 1;
    end
    if (width < 1) width = 1;
    return width;
  endfunction

endpackage

// File: rtl/prbs_step.sv
// prbs_step: purely combinational multi-bit Fibonacci LFSR advance.
// Shifts the LFSR OUT_W times in one clock; each shift inserts
// r[TAP_A] ^ r[TAP_B] at the top and that same bit becomes the next
// output bit, LSB first. Shared with the matching PRBS checker.
// Ports:
//   r      : current LFSR state
//   next_r : state after OUT_W shifts
//   word   : the OUT_W feedback bits, bit 0 produced first
module prbs_step #(
  parameter int LFSR_W = 17,
  parameter int OUT_W  = 16,
  parameter int TAP_A  = 3,
  parameter int TAP_B  = 0
) (
  input  logic [LFSR_W-1:0] r,
  output logic [LFSR_W-1:0] next_r,
  output logic [OUT_W-1:0]  word
);

  // One generate stage per output bit; each stage owns its own wires so
  // the ripple from stage to stage is a plain chain of distinct nets.
  for (genvar i = 0; i < OUT_W; i++) begin : g_stage
    logic [LFSR_W-1:0] c_in;
    logic [LFSR_W-1:0] c_out;
    logic              fb;

    if (i == 0) begin : g_first
      assign c_in = r;
    end else begin : g_next
      assign c_in = g_stage[i-1].c_out;
    end

    assign fb      = c_in[TAP_A] ^ c_in[TAP_B];
    assign c_out   = {fb, c_in[LFSR_W-1:1]};
    assign word[i] = fb;
  end

  assign next_r = g_stage[OUT_W-1].c_out;

endmodule

// File: rtl/prbs_gen_sync.sv
// prbs_gen_sync: orbit-aligned LFSR test-pattern generator for the ETROC
// readout path. Every clock it emits an OUT_W-bit word (bit 0 serialized
// first) and restarts from SEED every PERIOD clocks or on a bunch-counter
// reset, so the pattern stays locked to the LHC orbit.
// Ports:
//   clk          : 40 MHz clock
//   reset        : asynchronous, active-low reset
//   dis          : freeze all state and outputs while high
//   bcr          : single-cycle bunch-counter reset (realigns the frame)
//   enableBCID   : BCID counter runs when high, holds when low
//   bcid_preset  : BCID value loaded on bcr
//   mode         : 0 PRBS, 1 phase count, 2 FIXED, 3 inverted PRBS
//   data_out     : registered pattern word
//   BCID         : bunch-crossing counter
//   frame_start  : strobe aligned with the first word of every frame
module prbs_gen_sync
  import prbs_pkg::*;
#(
  parameter int                LFSR_W = 17,
  parameter int                OUT_W  = 16,
  parameter int                TAP_A  = 3,
  parameter int                TAP_B  = 0,
  parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED,
  parameter int                PERIOD = DEFAULT_PERIOD,
  parameter int                BCID_W = 12,
  parameter logic [OUT_W-1:0]  FIXED  = 16'hA5C3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dis,
  input  logic              bcr,
  input  logic              enableBCID,
  input  logic [BCID_W-1:0] bcid_preset,
  input  logic [1:0]        mode,
  output logic [OUT_W-1:0]  data_out,
  output logic [BCID_W-1:0] BCID,
  output logic              frame_start
);

  localparam int PHASE_W = clog2(PERIOD);

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PERIOD - 1);
  localparam logic [BCID_W-1:0]  BCID_LAST  = BCID_W'(PERIOD - 1);

  logic [LFSR_W-1:0]  r;
  logic [LFSR_W-1:0]  next_r;
  logic [OUT_W-1:0]   word;
  logic [OUT_W-1:0]   mode_word;
  logic [PHASE_W-1:0] phase;
  logic               phase_wrap;
  logic               frame_restart;
  logic [BCID_W-1:0]  bcid_inc;

  prbs_step #(
    .LFSR_W (LFSR_W),
    .OUT_W  (OUT_W),
    .TAP_A  (TAP_A),
    .TAP_B  (TAP_B)
  ) u_step (
    .r      (r),
    .next_r (next_r),
    .word   (word)
  );

  assign phase_wrap    = (phase == PHASE_LAST);
  assign frame_restart = bcr | phase_wrap;

  // BCID saturates into a wrap at PERIOD-1; an out-of-range preset also
  // falls into this branch and returns to 0 on the following step.
  assign bcid_inc = (BCID >= BCID_LAST) ? '0 : BCID + BCID_W'(1);

  // Output word selection; built from the pre-update state so the word
  // for r appears one clock after r is current.
  always_comb begin
    mode_word = word;
    unique case (mode)
      MODE_PRBS:     mode_word = word;
      MODE_PHASE:    mode_word = OUT_W'(phase);
      MODE_FIXED:    mode_word = FIXED;
      MODE_PRBS_INV: mode_word = ~word;
      default:       mode_word = word;
    endcase
  end

  // LFSR state and in-frame phase; a bcr or end of frame reloads SEED.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r     <= SEED;
      phase <= '0;
    end else if (!dis) begin
      if (frame_restart) begin
        r     <= SEED;
        phase <= '0;
      end else begin
        r     <= next_r;
        phase <= phase + PHASE_W'(1);
      end
    end
  end

  // Registered outputs; frame_start marks the word computed from SEED,
  // which is exactly the clock after phase was 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out    <= '0;
      frame_start <= 1'b0;
    end else if (!dis) begin
      data_out    <= mode_word;
      frame_start <= (phase == '0);
    end
  end

  // Bunch-crossing counter; bcr loads the preset instead of advancing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      BCID <= '0;
    end else if (!dis && enableBCID) begin
      if (bcr) begin
        BCID <= bcid_preset;
      end else begin
        BCID <= bcid_inc;
      end
    end
  end

endmodule

// File: tb/tb_prbs_gen_sync.sv
// tb_prbs_gen_sync: self-checking bench for prbs_gen_sync.
// The reference views the pattern as one long bit stream obeying
// s[n] = s[n-17+TAP_A] ^ s[n-17+TAP_B] with s[0..16] = SEED; the word at
// frame phase p is s[17+16p .. 17+16p+15]. A frame-level model tracks
// phase, BCID and the registered outputs from the behavioural rules.
module tb_prbs_gen_sync;

  localparam int              LFSR_W = 17;
  localparam int              OUT_W  = 16;
  localparam int              TAP_A  = 3;
  localparam int              TAP_B  = 0;
  localparam logic [16:0]     SEED   = 17'h0AAAA;
  localparam int              PERIOD = 3564;
  localparam int              BCID_W = 12;
  localparam logic [15:0]     FIXED  = 16'hA5C3;
  localparam int              NBITS  = LFSR_W + OUT_W * PERIOD;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              dis = 1'b0;
  logic              bcr = 1'b0;
  logic              enableBCID = 1'b0;
  logic [BCID_W-1:0] bcid_preset = '0;
  logic [1:0]        mode = 2'd0;
  logic [OUT_W-1:0]  data_out;
  logic [BCID_W-1:0] BCID;
  logic              frame_start;

  int n_compared = 0;
  int n_failed   = 0;

  // Reference stream and per-phase word table
  bit          seqbits [0:NBITS-1];
  logic [15:0] words   [0:PERIOD-1];

  // Model state
  int          m_phase = 0;
  int          m_bcid  = 0;
  logic [15:0] m_data  = '0;
  logic        m_fs    = 1'b0;
  bit          check_en = 1'b0;

  prbs_gen_sync #(
    .LFSR_W (LFSR_W),
    .OUT_W  (OUT_W),
    .TAP_A  (TAP_A),
    .TAP_B  (TAP_B),
    .SEED   (SEED),
    .PERIOD (PERIOD),
    .BCID_W (BCID_W),
    .FIXED  (FIXED)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .dis         (dis),
    .bcr         (bcr),
    .enableBCID  (enableBCID),
    .bcid_preset (bcid_preset),
    .mode        (mode),
    .data_out    (data_out),
    .BCID        (BCID),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Build the reference bit stream and word table
  initial begin
    for (int n = 0; n < NBITS; n++) begin
      if (n < LFSR_W) seqbits[n] = SEED[n];
      else seqbits[n] = seqbits[n-LFSR_W+TAP_A] ^ seqbits[n-LFSR_W+TAP_B];
    end
    for (int p = 0; p < PERIOD; p++) begin
      for (int b = 0; b < OUT_W; b++) begin
        words[p][b] = seqbits[LFSR_W + OUT_W*p + b];
      end
    end
  end

  // Frame-level behavioural model
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0;
      m_bcid  = 0;
      m_data  = '0;
      m_fs    = 1'b0;
    end else if (!dis) begin
      case (mode)
        2'd0: m_data = words[m_phase];
        2'd1: m_data = 16'(m_phase);
        2'd2: m_data = FIXED;
        default: m_data = ~words[m_phase];
      endcase
      m_fs = (m_phase == 0);
      if (enableBCID) begin
        if (bcr) m_bcid = int'(bcid_preset);
        else if (m_bcid >= PERIOD - 1) m_bcid = 0;
        else m_bcid = m_bcid + 1;
      end
      if (bcr || m_phase == PERIOD - 1) m_phase = 0;
      else m_phase = m_phase + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("data_out", 32'(data_out), 32'(m_data));
      checkOutput("BCID", 32'(BCID), 32'(m_bcid));
      checkOutput("frame_start", 32'(frame_start), 32'(m_fs));
    end
  end

  // Drive one clock worth of inputs, called at a falling edge
  task automatic applyStimulus(input logic d, input logic b, input logic [1:0] m,
                               input logic e, input logic [BCID_W-1:0] p);
    dis = d;
    bcr = b;
    mode = m;
    enableBCID = e;
    bcid_preset = p;
    @(negedge clk);
  endtask

  initial begin
    int budget;
    $display("[TB] start");
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    checkOutput("reset_data", 32'(data_out), 32'h0);
    checkOutput("reset_bcid", 32'(BCID), 32'h0);
    checkOutput("reset_fs", 32'(frame_start), 32'h0);
    reset = 1'b1;

    // First word after reset and frame period
    applyStimulus(0, 0, 2'd0, 0, '0);
    checkOutput("first_word", 32'(data_out), 32'h7FFF);
    checkOutput("first_fs", 32'(frame_start), 32'h1);
    repeat (PERIOD - 1) applyStimulus(0, 0, 2'd0, 0, '0);
    applyStimulus(0, 0, 2'd0, 0, '0);
    checkOutput("second_frame_word", 32'(data_out), 32'h7FFF);
    checkOutput("second_frame_fs", 32'(frame_start), 32'h1);
    repeat (PERIOD - 1) applyStimulus(0, 0, 2'd0, 0, '0);

    // bcr realignment with BCID preset, then a full BCID wrap
    repeat (777) applyStimulus(0, 0, 2'd0, 1, '0);
    applyStimulus(0, 1, 2'd0, 1, 12'd100);
    checkOutput("bcr_bcid", 32'(BCID), 32'd100);
    applyStimulus(0, 0, 2'd0, 1, '0);
    checkOutput("bcr_word", 32'(data_out), 32'h7FFF);
    checkOutput("bcr_fs", 32'(frame_start), 32'h1);
    checkOutput("bcr_bcid_next", 32'(BCID), 32'd101);
    repeat (PERIOD) applyStimulus(0, 0, 2'd0, 1, '0);

    // Out-of-range preset wraps to 0 on the following step
    applyStimulus(0, 1, 2'd0, 1, 12'd4000);
    checkOutput("preset_big", 32'(BCID), 32'd4000);
    applyStimulus(0, 0, 2'd0, 1, '0);
    checkOutput("preset_wrap", 32'(BCID), 32'd0);

    // Freeze window with a bcr that must be lost
    repeat (200) applyStimulus(0, 0, 2'd0, 1, '0);
    repeat (4) applyStimulus(1, 0, 2'd0, 1, '0);
    applyStimulus(1, 1, 2'd0, 1, 12'd55);
    repeat (5) applyStimulus(1, 0, 2'd0, 1, '0);
    repeat (50) applyStimulus(0, 0, 2'd0, 1, '0);

    // Mode sweep
    repeat (5) applyStimulus(0, 0, 2'd2, 1, '0);
    checkOutput("fixed_word", 32'(data_out), 32'hA5C3);
    repeat (50) applyStimulus(0, 0, 2'd3, 1, '0);
    repeat (PERIOD) applyStimulus(0, 0, 2'd1, 1, '0);
    repeat (100) applyStimulus(0, 0, 2'd0, 1, '0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      applyStimulus(($urandom_range(0, 15) == 0), ($urandom_range(0, 99) == 0),
                    2'($urandom_range(0, 3)), ($urandom_range(0, 7) != 0),
                    BCID_W'($urandom_range(0, 4095)));
    end

    // Asynchronous reset mid-frame at phase 1000
    budget = 0;
    while (m_phase != 1000 && budget < 2 * PERIOD) begin
      applyStimulus(0, 0, 2'd0, 1, '0);
      budget++;
    end
    if (m_phase != 1000) begin
      n_compared++;
      n_failed++;
      $display("[TB] FAIL phase_wait: got %0d expected 1000", m_phase);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_data", 32'(data_out), 32'h0);
    checkOutput("async_bcid", 32'(BCID), 32'h0);
    checkOutput("async_fs", 32'(frame_start), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    applyStimulus(0, 0, 2'd0, 0, '0);
    checkOutput("post_reset_word", 32'(data_out), 32'h7FFF);
    checkOutput("post_reset_bcid", 32'(BCID), 32'h0);
    repeat (20) applyStimulus(0, 0, 2'd0, 1, '0);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
